// File: rtl/fsm_resp_capture_if.sv
// Capture bundle between the response-capture block and its consumer.
// Stimulus/control in one direction, FIFO head and status in the other.
interface fsm_resp_capture_if #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            clr;
  logic            en;
  logic [16:0]     y_in;
  logic            rd_en;
  logic [TS_W+16:0] rd_data;
  logic            rd_valid;
  logic            full;
  logic [CW-1:0]   count;
  logic            overflow;
  logic [16:0]     sig;
  logic [1:0]      state;

  modport master (
    output clr, en, y_in, rd_en,
    input  rd_data, rd_valid, full, count,
    input  overflow, sig, state
  );

  modport slave (
    input  clr, en, y_in, rd_en,
    output rd_data, rd_valid, full, count,
    output overflow, sig, state
  );
endinterface

// File: rtl/fsm_resp_capture.sv
// Samples controller response vectors, logs changes with timestamps
// into a show-ahead FIFO and folds every sample into a MISR.
module fsm_resp_capture #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) (
  input logic clk,
  input logic rst,
  fsm_resp_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = TS_W + 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        st;
  logic [TS_W-1:0] ts;
  logic [16:0]   prev;
  logic [16:0]   sig;
  logic          ovf;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [W-1:0]  mem [DEPTH];

  logic        sample;
  logic        push_req;
  logic        pop;
  logic        is_full;
  logic        push_ok;
  logic        drop;
  logic [16:0] sig_nx;

  assign sample   = bus.en & ~bus.clr;
  assign push_req = sample & ((st == IDLE) | (bus.y_in != prev));
  assign is_full  = (cnt == CW'(DEPTH));
  assign pop      = bus.rd_en & (cnt != '0) & ~bus.clr;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req & (~is_full | pop);
  assign drop     = push_req & is_full & ~pop;

  // x^17 + x^3 + 1: feedback from bit 16 into taps 0 and 3.
  always_comb begin
    sig_nx    = {sig[15:0], sig[16]} ^ bus.y_in;
    sig_nx[3] = sig_nx[3] ^ sig[16];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      ts   <= '0;
      prev <= '0;
      sig  <= '0;
      ovf  <= 1'b0;
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
    end else if (bus.clr) begin
      st   <= IDLE;
      ts   <= '0;
      prev <= '0;
      sig  <= '0;
      ovf  <= 1'b0;
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
    end else begin
      unique case (st)
        IDLE:    if (bus.en) st <= RUN;
        RUN:     if (!bus.en) st <= PAUSE;
        PAUSE:   if (bus.en) st <= RUN;
        default: st <= IDLE;
      endcase
      if (sample) begin
        ts   <= ts + 1'b1;
        prev <= bus.y_in;
        sig  <= sig_nx;
      end
      if (drop) ovf <= 1'b1;
      if (push_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= {ts, bus.y_in};
  end

  assign bus.rd_data  = mem[rp];
  assign bus.rd_valid = (cnt != '0);
  assign bus.full     = is_full;
  assign bus.count    = cnt;
  assign bus.overflow = ovf;
  assign bus.sig      = sig;
  assign bus.state    = st;
endmodule

// File: tb/tb_fsm_resp_capture.sv
// Directed bench for fsm_resp_capture: queue-based reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_fsm_resp_capture;
  localparam int DEPTH = 8;
  localparam int TS_W  = 8;
  localparam int W     = TS_W + 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fsm_resp_capture_if #(.DEPTH(DEPTH), .TS_W(TS_W)) bus ();

  fsm_resp_capture #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: occupancy is the queue size, entries are {ts,y}.
  logic [W-1:0]    q[$];
  logic [TS_W-1:0] mts;
  logic [16:0]     mprev;
  logic [16:0]     msig;
  int              mst;
  logic            movf;

  always @(posedge clk or posedge rst) begin
    bit do_pop;
    bit do_push;
    logic fb;
    if (rst || bus.clr) begin
      q.delete();
      mts   = '0;
      mprev = '0;
      msig  = '0;
      mst   = 0;
      movf  = 1'b0;
    end else begin
      do_pop  = bus.rd_en && (q.size() > 0);
      do_push = bus.en && ((mst == 0) || (bus.y_in != mprev));
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        if (q.size() < DEPTH) q.push_back({mts, bus.y_in});
        else movf = 1'b1;
      end
      if (bus.en) begin
        fb    = msig[16];
        msig  = {msig[15:0], 1'b0} ^ (fb ? 17'h00009 : 17'h0) ^ bus.y_in;
        mts   = mts + 1'b1;
        mprev = bus.y_in;
        mst   = 1;
      end else if (mst == 1) begin
        mst = 2;
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("m_count", 64'(bus.count), 64'(q.size()));
    cmp("m_rd_valid", 64'(bus.rd_valid), 64'(q.size() != 0));
    cmp("m_full", 64'(bus.full), 64'(q.size() == DEPTH));
    cmp("m_overflow", 64'(bus.overflow), 64'(movf));
    cmp("m_sig", 64'(bus.sig), 64'(msig));
    cmp("m_state", 64'(bus.state), 64'(mst));
    if (q.size() > 0) cmp("m_rd_data", 64'(bus.rd_data), 64'(q[0]));
  end

  task automatic cyc(input logic e, input logic [16:0] y,
                     input logic r, input logic c);
    bus.en    = e;
    bus.y_in  = y;
    bus.rd_en = r;
    bus.clr   = c;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(1'b0, 17'h0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.en = 1'b0; bus.y_in = '0; bus.rd_en = 1'b0; bus.clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    cmp("rst_count", 64'(bus.count), 64'd0);
    cmp("rst_valid", 64'(bus.rd_valid), 64'd0);
    cmp("rst_state", 64'(bus.state), 64'd0);
    cmp("rst_sig", 64'(bus.sig), 64'd0);
    rst = 1'b0;
    idle();

    // first sample from IDLE, then pause
    cyc(1'b1, 17'h00001, 1'b0, 1'b0);
    cyc(1'b0, 17'h00001, 1'b0, 1'b0);
    cmp("r34_count", 64'(bus.count), 64'd1);
    cmp("r34_data", 64'(bus.rd_data), 64'({8'd0, 17'h00001}));
    cmp("r34_sig", 64'(bus.sig), 64'h1);
    cmp("r34_state", 64'(bus.state), 64'd2);

    cyc(1'b1, 17'h00000, 1'b0, 1'b0);
    cmp("r35_count", 64'(bus.count), 64'd2);
    cmp("r35_sig", 64'(bus.sig), 64'h2);
    cyc(1'b0, 17'h0, 1'b1, 1'b0);
    cmp("r35_head", 64'(bus.rd_data), 64'({8'd1, 17'h0}));
    cyc(1'b0, 17'h0, 1'b1, 1'b0);
    cyc(1'b0, 17'h0, 1'b1, 1'b0);
    cmp("empty_pop", 64'(bus.count), 64'd0);

    // held vector: one push only
    cyc(1'b0, 17'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 17'h00105, 1'b0, 1'b0);
    cmp("r36_count", 64'(bus.count), 64'd1);
    cyc(1'b1, 17'h0, 1'b1, 1'b0);
    cmp("r36_ts", 64'(bus.rd_data), 64'({8'd10, 17'h0}));

    // overflow on 10 distinct vectors
    cyc(1'b0, 17'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 17'(i + 1), 1'b0, 1'b0);
    idle();
    cmp("r37_count", 64'(bus.count), 64'd8);
    cmp("r37_full", 64'(bus.full), 64'd1);
    cmp("r37_ovf", 64'(bus.overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      cmp("r37_ts", 64'(bus.rd_data[W-1:17]), 64'(i));
      cyc(1'b0, 17'h0, 1'b1, 1'b0);
    end

    // full FIFO with simultaneous push and pop
    cyc(1'b0, 17'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 17'(i + 1), 1'b0, 1'b0);
    cyc(1'b1, 17'h1ffff, 1'b1, 1'b0);
    cmp("r38_count", 64'(bus.count), 64'd8);
    cmp("r38_ovf", 64'(bus.overflow), 64'd0);
    cmp("r38_head", 64'(bus.rd_data[W-1:17]), 64'd1);

    // clr beats en and rd_en
    cyc(1'b0, 17'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 17'(i + 7), 1'b0, 1'b0);
    cyc(1'b1, 17'h5, 1'b1, 1'b1);
    cmp("r39_count", 64'(bus.count), 64'd0);
    cmp("r39_sig", 64'(bus.sig), 64'd0);
    cmp("r39_state", 64'(bus.state), 64'd0);
    cyc(1'b1, 17'h3, 1'b0, 1'b0);
    cmp("r39_push", 64'(bus.rd_data), 64'({8'd0, 17'h3}));

    // asynchronous reset mid-run
    for (int i = 0; i < 3; i++) cyc(1'b1, 17'(i + 20), 1'b0, 1'b0);
    bus.en = 1'b0;
    #1 rst = 1'b1;
    #1;
    cmp("arst_count", 64'(bus.count), 64'd0);
    cmp("arst_state", 64'(bus.state), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    cyc(1'b1, 17'h0, 1'b0, 1'b0);
    cmp("arst_push", 64'(bus.count), 64'd1);
    cmp("arst_data", 64'(bus.rd_data), 64'({8'd0, 17'h0}));

    // mixed traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [16:0] y;
      case ($urandom % 4)
        0: y = 17'h0;
        1: y = 17'h1;
        2: y = 17'h5;
        default: y = 17'h1ffff;
      endcase
      cyc(($urandom % 4) != 0, y, ($urandom % 3) == 0,
          ($urandom % 40) == 0);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsm_resp_capture.md
FSM_RESP_CAPTURE -- requirements
Module: fsm_resp_capture

Interface
REQ-001 Parameter DEPTH, default 8: number of FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Parameter TS_W, default 8: width of the timestamp counter.
REQ-003 clk  input  1: clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1: reset, asynchronous, active-high.
REQ-005 clr  input  1: synchronous clear of all capture state.
REQ-006 en  input  1: capture enable.
REQ-007 y_in  input  17: response vector y17..y1 from the controller; bit 0 = y1.
REQ-008 rd_en  input  1: pop the FIFO head.
REQ-009 rd_data  output  TS_W+17: FIFO head, laid out as {timestamp, y}; show-ahead.
REQ-010 rd_valid  output  1: FIFO is not empty.
REQ-011 full  output  1: FIFO holds DEPTH entries.
REQ-012 count  output  clog2(DEPTH)+1: FIFO occupancy.
REQ-013 overflow  output  1: sticky flag, set when an event is dropped.
REQ-014 sig  output  17: MISR signature of all sampled vectors.
REQ-015 state  output  2: IDLE=0, RUN=1, PAUSE=2.

Function
REQ-016 FSM transitions:
- IDLE --en--> RUN.
- RUN --!en--> PAUSE.
- PAUSE --en--> RUN.
- Any state --clr--> IDLE; clr has priority over en.
REQ-017 Sample cycle: any rising edge with en=1 and clr=0, in any state.
REQ-018 Timestamp counter ts SHALL increment by 1 on every sample cycle and wrap modulo 2^TS_W; the pushed timestamp is the pre-increment value.
REQ-019 Push condition: a sample cycle taken from IDLE, OR a sample cycle with y_in != prev.
- prev SHALL be loaded with y_in on every sample cycle.
- Entering PAUSE and returning to RUN SHALL NOT force a push.
REQ-020 Pushed entry: {ts, y_in}.
REQ-021 Pop: rd_en=1 with count>0 removes the head. rd_en with count=0 SHALL be ignored, with no state change.
REQ-022 Push while full without a same-cycle pop: the entry SHALL be dropped, overflow set, count unchanged.
REQ-023 Push while full with a same-cycle pop: both SHALL occur; count stays at DEPTH; overflow is not set.
REQ-024 Push and pop on a non-empty, non-full FIFO: count unchanged, order preserved.
REQ-025 Pop occupancy update: count SHALL decrement in the cycle after the popping edge; rd_data SHALL present the new head in that same cycle.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 MISR update on each sample cycle, polynomial x^17+x^3+1:
- sig'[0] = sig[16]^y[0]
- sig'[3] = sig[2]^sig[16]^y[3]
- sig'[i] = sig[i-1]^y[i] for all other i
REQ-028 Outside sample cycles, ts, prev and sig SHALL hold their values.
REQ-029 clr SHALL, at the next edge:
- empty the FIFO;
- zero ts, sig, prev and overflow;
- set state to IDLE;
- perform no push and no pop, even if rd_en or en is asserted.
REQ-030 rd_data SHALL be don't-care when rd_valid=0.
REQ-031 full SHALL equal (count==DEPTH); rd_valid SHALL equal (count!=0).

Reset
REQ-032 While rst=1, all outputs and registers SHALL take these values immediately, without waiting for a clock edge:
- state=IDLE;
- count=0, rd_valid=0, full=0, overflow=0;
- sig=0, ts=0, prev=0;
- FIFO pointers=0.
REQ-033 Reset asserted mid-operation SHALL discard all FIFO contents; the first sample after release SHALL be treated as an IDLE sample (forced push, ts=0).

Verification
REQ-034 Reset, then en=1 for one cycle with y_in=17'h00001, then en=0 -> one entry {ts=0, y=17'h00001}; sig=17'h00001; state=PAUSE.
REQ-035 From REQ-034, en=1 and y_in=17'h00000 for one cycle -> entry {ts=1, y=0} pushed; sig=17'h00002; count=2.
REQ-036 en=1 with y_in held at 17'h00105 for 10 cycles, DEPTH=8 -> exactly one push; ts=10 afterwards.
REQ-037 DEPTH=8, 10 distinct consecutive vectors, rd_en=0 -> count=8, full=1, overflow=1; pops return ts=0..7 in order.
REQ-038 Full FIFO, with a new vector and rd_en in the same cycle -> count stays 8, overflow stays 0, the head advances.
REQ-039 clr asserted together with en=1 and rd_en=1 on a half-full FIFO -> count=0, sig=0, ts=0, state=IDLE; the next en sample pushes with ts=0.
